// File: rtl/motion_ctrl_nd.sv
// motion_ctrl_nd: keyboard-driven Euler-angle and camera-translation controller
// with MANUAL / AUTO-spin / HOME modes, all state advancing on frame strobes.
`default_nettype none

module motion_ctrl_nd #(
   parameter int              AW        = 12,
   parameter int              WI        = 8,
   parameter int              WF        = 8,
   parameter logic [AW-1:0]   TWO_PI    = 12'h648,
   parameter logic [AW-1:0]   V_MAX     = 12'h020,
   parameter logic [AW-1:0]   ACCEL     = 12'h002,
   parameter logic [AW-1:0]   FRICTION  = 12'h001,
   parameter logic [AW-1:0]   AUTO_V    = 12'h010,
   parameter logic [AW-1:0]   HOME_STEP = 12'h010,
   parameter logic [WI+WF-1:0] POS_STEP = 16'h0020,
   parameter logic [WI+WF-1:0] POS_LIM  = 16'h1000,
   parameter logic [WI+WF-1:0] Z_INIT   = 16'hF800
) (
   input  logic                    Clk,
   input  logic                    Reset_n,
   input  logic                    frame_clk_rising_edge,
   input  logic [7:0]              keycode,
   output logic [AW-1:0]           alpha,
   output logic [AW-1:0]           beta,
   output logic [AW-1:0]           gamma,
   output logic signed [WI+WF-1:0] x,
   output logic signed [WI+WF-1:0] y,
   output logic signed [WI+WF-1:0] z,
   output logic [1:0]              mode,
   output logic                    busy
);

   localparam int W = WI + WF;
   localparam logic [AW-1:0]        c_HALF_PI2 = TWO_PI >> 1;
   localparam logic signed [AW:0]   c_TWO_PI_X = $signed({1'b0, TWO_PI});
   localparam logic signed [AW-1:0] c_VMAX     = $signed(V_MAX);
   localparam logic signed [AW-1:0] c_ACC      = $signed(ACCEL);
   localparam logic signed [AW-1:0] c_FRIC     = $signed(FRICTION);
   localparam logic signed [W:0]    c_LIM_X    = $signed({1'b0, POS_LIM});

   typedef enum logic [1:0] {S_MANUAL = 2'd0, S_AUTO = 2'd1, S_HOME = 2'd2} state_t;

   state_t                r_mode;
   logic                  r_busy;
   logic [7:0]            r_last_key;
   logic [AW-1:0]         r_alpha, r_beta, r_gamma;
   logic signed [AW-1:0]  r_alpha_v, r_beta_v, r_gamma_v;
   logic signed [W-1:0]   r_x, r_y, r_z;

   // Wrap checks use the widened sum; the result itself is plain modular arithmetic.
   function automatic logic [AW-1:0] f_step(input logic [AW-1:0] a, input logic signed [AW-1:0] v);
      logic signed [AW:0] s;
      logic [AW-1:0]      lo;
      s  = $signed({1'b0, a}) + $signed({v[AW-1], v});
      lo = a + v;
      if (s >= c_TWO_PI_X)  return lo - TWO_PI;
      else if (s < 0)       return lo + TWO_PI;
      else                  return lo;
   endfunction

   function automatic logic signed [AW-1:0] f_vel(input logic signed [AW-1:0] v,
                                                  input logic inc, input logic dec);
      if (inc)                               return (v > c_VMAX - c_ACC) ? c_VMAX : v + c_ACC;
      else if (dec)                          return (v < c_ACC - c_VMAX) ? -c_VMAX : v - c_ACC;
      else if (v <= c_FRIC && v >= -c_FRIC)  return '0;
      else if (v > 0)                        return v - c_FRIC;
      else                                   return v + c_FRIC;
   endfunction

   function automatic logic [AW-1:0] f_home(input logic [AW-1:0] a);
      if (a == '0)               return '0;
      else if (a < c_HALF_PI2)   return (a < HOME_STEP) ? '0 : a - HOME_STEP;
      else if (TWO_PI - a <= HOME_STEP) return '0;
      else                       return a + HOME_STEP;
   endfunction

   function automatic logic signed [W-1:0] f_pos(input logic signed [W-1:0] p,
                                                 input logic signed [W-1:0] d);
      logic signed [W:0] s;
      s = $signed({p[W-1], p}) + $signed({d[W-1], d});
      if (s > c_LIM_X)        return $signed(POS_LIM);
      else if (s < -c_LIM_X)  return $signed(-POS_LIM);
      else                    return p + d;
   endfunction

   logic w_k_w, w_k_s, w_k_a, w_k_d, w_k_q, w_k_e;
   logic w_press_space, w_press_r, w_auto_next;
   logic signed [W-1:0] w_dx, w_dy, w_dz;

   assign w_k_w = (keycode == 8'h1A);
   assign w_k_s = (keycode == 8'h16);
   assign w_k_a = (keycode == 8'h04);
   assign w_k_d = (keycode == 8'h07);
   assign w_k_q = (keycode == 8'h14);
   assign w_k_e = (keycode == 8'h08);
   assign w_press_space = (keycode == 8'h2C) && (r_last_key != 8'h2C);
   assign w_press_r     = (keycode == 8'h15) && (r_last_key != 8'h15);
   assign w_auto_next   = (r_mode == S_AUTO) ^ w_press_space;

   assign w_dx = (keycode == 8'h4F) ? $signed(POS_STEP) : (keycode == 8'h50) ? -$signed(POS_STEP) : '0;
   assign w_dy = (keycode == 8'h1D) ? $signed(POS_STEP) : (keycode == 8'h1B) ? -$signed(POS_STEP) : '0;
   assign w_dz = (keycode == 8'h52) ? $signed(POS_STEP) : (keycode == 8'h51) ? -$signed(POS_STEP) : '0;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_mode     <= S_MANUAL;
         r_busy     <= 1'b0;
         r_last_key <= '0;
         r_alpha    <= '0;
         r_beta     <= '0;
         r_gamma    <= '0;
         r_alpha_v  <= '0;
         r_beta_v   <= '0;
         r_gamma_v  <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_z        <= $signed(Z_INIT);
      end else if (frame_clk_rising_edge) begin
         r_last_key <= keycode;
         if (r_mode == S_HOME) begin
            r_alpha <= f_home(r_alpha);
            r_beta  <= f_home(r_beta);
            r_gamma <= f_home(r_gamma);
            if (r_alpha == '0 && r_beta == '0 && r_gamma == '0) begin
               r_mode <= S_MANUAL;
               r_busy <= 1'b0;
            end
         end else begin
            r_alpha <= f_step(r_alpha, r_alpha_v);
            r_beta  <= f_step(r_beta,  r_beta_v);
            r_gamma <= f_step(r_gamma, r_gamma_v);
            if (w_press_r) begin
               r_mode    <= S_HOME;
               r_busy    <= 1'b1;
               r_alpha_v <= '0;
               r_beta_v  <= '0;
               r_gamma_v <= '0;
               r_x       <= '0;
               r_y       <= '0;
               r_z       <= $signed(Z_INIT);
            end else begin
               // The post-transition mode decides whether beta is forced to spin.
               r_mode    <= w_auto_next ? S_AUTO : S_MANUAL;
               r_alpha_v <= f_vel(r_alpha_v, w_k_q, w_k_e);
               r_beta_v  <= w_auto_next ? $signed(AUTO_V) : f_vel(r_beta_v, w_k_w, w_k_s);
               r_gamma_v <= f_vel(r_gamma_v, w_k_a, w_k_d);
               r_x       <= f_pos(r_x, w_dx);
               r_y       <= f_pos(r_y, w_dy);
               r_z       <= f_pos(r_z, w_dz);
            end
         end
      end
   end

   assign alpha = r_alpha;
   assign beta  = r_beta;
   assign gamma = r_gamma;
   assign x     = r_x;
   assign y     = r_y;
   assign z     = r_z;
   assign mode  = r_mode;
   assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_motion_ctrl_nd.sv
// tb_motion_ctrl_nd: directed-vector bench for motion_ctrl_nd with hand-computed expectations.
`default_nettype none

module tb_motion_ctrl_nd;

   logic              Clk = 1'b0;
   logic              Reset_n = 1'b0;
   logic              strobe = 1'b0;
   logic [7:0]        keycode = 8'h00;
   logic [11:0]       alpha, beta, gamma;
   logic signed [15:0] x, y, z;
   logic [1:0]        mode;
   logic              busy;

   int n_vec = 0;
   int n_bad = 0;

   always #5 Clk = ~Clk;

   motion_ctrl_nd dut (
      .Clk                   (Clk),
      .Reset_n               (Reset_n),
      .frame_clk_rising_edge (strobe),
      .keycode               (keycode),
      .alpha                 (alpha),
      .beta                  (beta),
      .gamma                 (gamma),
      .x                     (x),
      .y                     (y),
      .z                     (z),
      .mode                  (mode),
      .busy                  (busy)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One strobe per two clocks, keycode held for the strobe; returns on a falling edge.
   task automatic frames(input logic [7:0] k, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         keycode = k;
         strobe  = 1'b1;
         @(negedge Clk);
         strobe  = 1'b0;
      end
   endtask

   task automatic pulse_reset();
      @(negedge Clk);
      Reset_n = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge Clk);
      check("rst_mode", {14'b0, mode}, 16'h0000);
      check("rst_z", z, 16'hF800);
      Reset_n = 1'b1;

      frames(8'h00, 5);
      check("idle_alpha", {4'b0, alpha}, 16'h0000);
      check("idle_beta",  {4'b0, beta},  16'h0000);
      check("idle_gamma", {4'b0, gamma}, 16'h0000);
      check("idle_x", x, 16'h0000);
      check("idle_y", y, 16'h0000);
      check("idle_z", z, 16'hF800);
      check("idle_mode", {14'b0, mode}, 16'h0000);
      check("idle_busy", {15'b0, busy}, 16'h0000);

      // Hold w: beta ramps to full speed, then wraps past TWO_PI
      for (int i = 0; i < 59; i++) begin
         frames(8'h1A, 1);
         check("beta_range", {15'b0, beta < 12'h648}, 16'h0001);
         if (i == 15) check("beta_ramp16", {4'b0, beta}, 16'h00F0);
      end
      check("beta_wrap59", {4'b0, beta}, 16'h0008);

      // Release (unknown key acts as none): 32+31+...+1 = 0x210 more
      frames(8'h99, 32);
      check("beta_decay", {4'b0, beta}, 16'h0218);
      frames(8'h00, 3);
      check("beta_stopped", {4'b0, beta}, 16'h0218);

      frames(8'h07, 16);
      check("gamma_neg16", {4'b0, gamma}, 16'h0558);
      frames(8'h00, 32);
      check("gamma_decay", {4'b0, gamma}, 16'h0348);
      frames(8'h00, 2);
      check("gamma_stopped", {4'b0, gamma}, 16'h0348);
      check("alpha_untouched", {4'b0, alpha}, 16'h0000);

      frames(8'h4F, 10);
      check("x_right10", x, 16'h0140);
      frames(8'h4F, 190);
      check("x_sat_pos", x, 16'h1000);
      frames(8'h50, 300);
      check("x_sat_neg", x, 16'hF000);
      check("y_still", y, 16'h0000);
      check("z_still", z, 16'hF800);

      // Build alpha = 0x63C, beta = 0x00C with all velocities settled at 0
      pulse_reset();
      frames(8'h08, 2);
      frames(8'h00, 4);
      check("alpha_setup", {4'b0, alpha}, 16'h063C);
      frames(8'h1A, 2);
      frames(8'h00, 4);
      check("beta_setup", {4'b0, beta}, 16'h000C);
      frames(8'h52, 4);
      check("z_up4", z, 16'hF880);

      frames(8'h15, 1);
      check("home_mode", {14'b0, mode}, 16'h0002);
      check("home_busy", {15'b0, busy}, 16'h0001);
      check("home_z", z, 16'hF800);
      check("home_entry_alpha", {4'b0, alpha}, 16'h063C);
      frames(8'h15, 1);
      check("home_alpha0", {4'b0, alpha}, 16'h0000);
      check("home_beta0", {4'b0, beta}, 16'h0000);
      check("home_still", {14'b0, mode}, 16'h0002);
      frames(8'h4F, 1);
      check("home_exit", {14'b0, mode}, 16'h0000);
      check("home_exit_busy", {15'b0, busy}, 16'h0000);
      check("home_key_ignored", x, 16'h0000);

      frames(8'h2C, 1);
      check("auto_enter", {14'b0, mode}, 16'h0001);
      check("auto_beta0", {4'b0, beta}, 16'h0000);
      frames(8'h2C, 3);
      check("auto_hold_mode", {14'b0, mode}, 16'h0001);
      check("auto_beta3", {4'b0, beta}, 16'h0030);
      frames(8'h00, 1);
      check("auto_beta4", {4'b0, beta}, 16'h0040);
      frames(8'h2C, 1);
      check("auto_leave", {14'b0, mode}, 16'h0000);
      check("auto_leave_beta", {4'b0, beta}, 16'h0050);

      frames(8'h00, 1);
      frames(8'h2C, 1);
      check("auto_again", {14'b0, mode}, 16'h0001);
      @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      check("async_mode", {14'b0, mode}, 16'h0000);
      check("async_beta", {4'b0, beta}, 16'h0000);
      check("async_z", z, 16'hF800);
      @(negedge Clk);
      Reset_n = 1'b1;
      frames(8'h00, 2);
      check("post_rst_beta", {4'b0, beta}, 16'h0000);
      check("post_rst_mode", {14'b0, mode}, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
